// File: rtl/cc_random_scheduler.sv
// Obstacle-row source scheduler: every SCHED_PERIOD ticks it picks a mux select
// from an 8-bit LFSR, applies repeat/gap spacing rules and offers it via load/ack.
module cc_random_scheduler #(
    parameter int         SCHED_SELECTWIDTH = 2,
    parameter int         SCHED_PERIOD      = 4,
    parameter int         SCHED_GAP         = 2,
    parameter int         SCHED_CNTWIDTH    = 4,
    parameter logic [7:0] SCHED_SEED        = 8'hA5
) (
    input  logic                         CC_RANDOMSCHED_CLOCK_50,
    input  logic                         CC_RANDOMSCHED_RESET_InLow,
    input  logic                         CC_RANDOMSCHED_enable_In,
    input  logic                         CC_RANDOMSCHED_tick_In,
    input  logic                         CC_RANDOMSCHED_ack_In,
    output logic [SCHED_SELECTWIDTH-1:0] CC_RANDOMSCHED_select_OutBUS,
    output logic                         CC_RANDOMSCHED_load_Out,
    output logic                         CC_RANDOMSCHED_overrun_Out,
    output logic [1:0]                   CC_RANDOMSCHED_dbgState_OutBUS
);

    // Handshake: load is the valid, ack the ready. A select is transferred on the
    // rising edge where load and ack are both high; select is registered one cycle
    // before load rises and is held unchanged until that transfer.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        DECIDE = 2'd2,
        REQ    = 2'd3
    } state_t;

    localparam logic [7:0] SEED_V = (SCHED_SEED == 8'h00) ? 8'h01 : SCHED_SEED;
    localparam logic [SCHED_CNTWIDTH-1:0] LAST_V  = SCHED_CNTWIDTH'(SCHED_PERIOD - 1);
    localparam logic [SCHED_CNTWIDTH-1:0] GAP_V   = SCHED_CNTWIDTH'(SCHED_GAP);
    localparam logic [SCHED_CNTWIDTH-1:0] CNT_ONE = SCHED_CNTWIDTH'(1);

    state_t                        state_q, state_d;
    logic [SCHED_CNTWIDTH-1:0]     tick_cnt_q, tick_cnt_d;
    logic [SCHED_CNTWIDTH-1:0]     gap_cnt_q, gap_cnt_d;
    logic [1:0]                    last_random_q, last_random_d;
    logic [7:0]                    lfsr_q, lfsr_d;
    logic [SCHED_SELECTWIDTH-1:0]  select_q, select_d;
    logic                          load_q, load_d;
    logic                          overrun_q, overrun_d;
    logic                          expired_q, expired_d;
    logic [1:0]                    cand;
    logic                          cnt_at_last;

    assign cand        = lfsr_q[1:0];
    assign cnt_at_last = (tick_cnt_q == LAST_V);

    always_ff @(posedge CC_RANDOMSCHED_CLOCK_50 or negedge CC_RANDOMSCHED_RESET_InLow) begin
        if (!CC_RANDOMSCHED_RESET_InLow) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            last_random_q <= 2'd0;
            lfsr_q        <= SEED_V;
            select_q      <= '0;
            load_q        <= 1'b0;
            overrun_q     <= 1'b0;
            expired_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            last_random_q <= last_random_d;
            lfsr_q        <= lfsr_d;
            select_q      <= select_d;
            load_q        <= load_d;
            overrun_q     <= overrun_d;
            expired_q     <= expired_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        last_random_d = last_random_q;
        select_d      = select_q;
        load_d        = load_q;
        overrun_d     = overrun_q;
        expired_d     = expired_q;
        lfsr_d        = lfsr_q;

        if (CC_RANDOMSCHED_enable_In) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end

        if (!CC_RANDOMSCHED_enable_In) begin
            state_d       = IDLE;
            tick_cnt_d    = '0;
            gap_cnt_d     = '0;
            last_random_d = 2'd0;
            select_d      = '0;
            load_d        = 1'b0;
            overrun_d     = 1'b0;
            expired_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = COUNT;
                    tick_cnt_d = '0;
                end
                COUNT: begin
                    if (CC_RANDOMSCHED_tick_In) begin
                        if (cnt_at_last) begin
                            state_d    = DECIDE;
                            tick_cnt_d = '0;
                        end else begin
                            tick_cnt_d = tick_cnt_q + CNT_ONE;
                        end
                    end
                end
                DECIDE: begin
                    if (CC_RANDOMSCHED_tick_In && !cnt_at_last) begin
                        tick_cnt_d = tick_cnt_q + CNT_ONE;
                    end
                    if (gap_cnt_q != '0) begin
                        select_d  = '0;
                        gap_cnt_d = gap_cnt_q - CNT_ONE;
                    end else if (cand != 2'd0 && cand == last_random_q) begin
                        select_d = '0;
                    end else begin
                        select_d = SCHED_SELECTWIDTH'(cand);
                        if (cand != 2'd0) begin
                            last_random_d = cand;
                            gap_cnt_d     = GAP_V;
                        end
                    end
                    load_d  = 1'b0;
                    state_d = REQ;
                end
                REQ: begin
                    load_d = 1'b1;
                    // A slot that expires while still waiting saturates the counter and is remembered.
                    if (CC_RANDOMSCHED_tick_In) begin
                        if (cnt_at_last) begin
                            overrun_d = 1'b1;
                            expired_d = 1'b1;
                        end else begin
                            tick_cnt_d = tick_cnt_q + CNT_ONE;
                        end
                    end
                    if (load_q && CC_RANDOMSCHED_ack_In) begin
                        load_d = 1'b0;
                        if (expired_q || (CC_RANDOMSCHED_tick_In && cnt_at_last)) begin
                            state_d    = DECIDE;
                            tick_cnt_d = '0;
                            expired_d  = 1'b0;
                        end else begin
                            state_d = COUNT;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign CC_RANDOMSCHED_select_OutBUS   = select_q;
    assign CC_RANDOMSCHED_load_Out        = load_q;
    assign CC_RANDOMSCHED_overrun_Out     = overrun_q;
    assign CC_RANDOMSCHED_dbgState_OutBUS = state_q;

endmodule

// File: tb/tb_cc_random_scheduler.sv
// Directed phases with randomized tick/ack timing, checked against an LFSR and
// spacing-rule reference model kept in the bench.
module tb_cc_random_scheduler;

  localparam int P   = 4;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       tick;
  logic       ack;
  logic [1:0] sel;
  logic       load;
  logic       ovr;
  logic [1:0] dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mlfsr;
  logic [1:0] m_last;
  int         m_gap;
  logic [1:0] cur_sel;
  int         ticks;
  int         cyc = 0;
  logic [1:0] exp_q[$];

  cc_random_scheduler dut (
    .CC_RANDOMSCHED_CLOCK_50       (clk),
    .CC_RANDOMSCHED_RESET_InLow    (rst_n),
    .CC_RANDOMSCHED_enable_In      (en),
    .CC_RANDOMSCHED_tick_In        (tick),
    .CC_RANDOMSCHED_ack_In         (ack),
    .CC_RANDOMSCHED_select_OutBUS  (sel),
    .CC_RANDOMSCHED_load_Out       (load),
    .CC_RANDOMSCHED_overrun_Out    (ovr),
    .CC_RANDOMSCHED_dbgState_OutBUS(dbg_state)
  );

  // clock / reset
  always #10 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // driver: apply inputs for one clock, then advance the reference LFSR
  task automatic step(input logic e, input logic t, input logic a);
    en   = e;
    tick = t;
    ack  = a;
    @(posedge clk);
    if (e) mlfsr = {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
    cyc++;
    #1;
  endtask

  // reference decision from the spacing rules, using the LFSR value of the decide cycle
  task automatic model_decide(output logic [1:0] d);
    logic [1:0] c;
    c = mlfsr[1:0];
    if (m_gap != 0) begin
      d = 2'd0;
      m_gap--;
    end else if (c != 2'd0 && c == m_last) begin
      d = 2'd0;
    end else begin
      d = c;
      if (c != 2'd0) begin
        m_last = c;
        m_gap  = GAP;
      end
    end
  endtask

  task automatic model_clear();
    m_gap   = 0;
    m_last  = 2'd0;
    cur_sel = 2'd0;
    ticks   = 0;
  endtask

  // deliver ticks (load known low) until a slot terminates; returns the model decision
  task automatic tick_until_decide(output logic [1:0] d);
    d = 2'd0;
    for (int k = 0; k < P; k++) begin
      repeat ($urandom_range(2, 4)) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      ticks++;
      if (ticks % P == 0) begin
        model_decide(d);
        break;
      end
    end
  endtask

  // select appears one edge after DECIDE, load the edge after that
  task automatic await_load(input logic [1:0] d);
    step(1'b1, 1'b0, 1'b0);
    check1("load_before_req", load, 1'b0);
    check2("select_at_decide", sel, d);
    step(1'b1, 1'b0, 1'b0);
    check1("load_rise", load, 1'b1);
    check2("select_at_load", sel, d);
    cur_sel = d;
  endtask

  // random tick spacing and ack delay; every cycle checks load and select
  task automatic run_slots(input int n);
    int         done;
    int         tick_cd;
    int         load_at;
    int         ack_at;
    int         guard;
    logic       exp_load;
    logic [1:0] exp_sel;
    logic [1:0] d;
    logic       t;
    logic       a;
    done     = 0;
    tick_cd  = $urandom_range(1, 3);
    load_at  = -1;
    ack_at   = -1;
    guard    = 0;
    exp_load = 1'b0;
    exp_sel  = cur_sel;
    while (done < n && guard < 5000) begin
      guard++;
      t = (tick_cd == 0);
      a = (cyc + 1 == ack_at);
      if (!a && load_at < 0 && !exp_load && $urandom_range(0, 7) == 0) a = 1'b1;
      step(1'b1, t, a);
      if (a && exp_load) begin
        exp_load = 1'b0;
        ack_at   = -1;
        done++;
      end
      if (load_at >= 0 && cyc == load_at - 1 && exp_q.size() > 0) exp_sel = exp_q.pop_front();
      if (load_at >= 0 && cyc == load_at) begin
        exp_load = 1'b1;
        ack_at   = cyc + $urandom_range(1, 3);
        load_at  = -1;
      end
      if (t) begin
        ticks++;
        tick_cd = $urandom_range(2, 5);
        if (ticks % P == 0) begin
          model_decide(d);
          exp_q.push_back(d);
          load_at = cyc + 2;
        end
      end else begin
        tick_cd--;
      end
      check1("slot_load", load, exp_load);
      check2("slot_select", sel, exp_sel);
    end
    if (guard >= 5000) begin
      vectors++;
      miscompares++;
      $error("FAIL run_slots_budget observed=%0d expected=%0d slots", done, n);
    end
    cur_sel = exp_sel;
  endtask

  initial begin
    logic [1:0] d;
    logic [1:0] d2;

    // reset and disabled idle
    rst_n = 1'b0;
    en    = 1'b0;
    tick  = 1'b0;
    ack   = 1'b0;
    mlfsr = 8'hA5;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check1("reset_load", load, 1'b0);
    check2("reset_select", sel, 2'd0);
    check1("reset_overrun", ovr, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check1("idle_load", load, 1'b0);
      check2("idle_select", sel, 2'd0);
      check1("idle_overrun", ovr, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end

    // enable and run randomized slots against the model
    step(1'b1, 1'b0, 1'b0);
    model_clear();
    run_slots(40);
    check1("no_overrun_normal", ovr, 1'b0);

    // overrun: hold ack low across five more ticks
    tick_until_decide(d);
    await_load(d);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1, 1'b0);
      check1("overrun_tick", ovr, (k >= P) ? 1'b1 : 1'b0);
      check1("overrun_load_held", load, 1'b1);
      check2("overrun_select_held", sel, d);
      repeat (2) step(1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1);
    check1("overrun_ack_load", load, 1'b0);
    ticks = 0;
    model_decide(d2);
    await_load(d2);
    check1("overrun_sticky", ovr, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check1("overrun_ack2_load", load, 1'b0);
    check1("overrun_still_sticky", ovr, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    model_clear();
    check1("disable_overrun", ovr, 1'b0);
    check1("disable_load", load, 1'b0);
    check2("disable_select", sel, 2'd0);

    // enable drop while a request is pending
    step(1'b1, 1'b0, 1'b0);
    model_clear();
    tick_until_decide(d);
    await_load(d);
    step(1'b0, 1'b0, 1'b0);
    model_clear();
    check1("drop_req_load", load, 1'b0);
    check2("drop_req_select", sel, 2'd0);
    step(1'b1, 1'b0, 1'b0);
    model_clear();
    run_slots(6);

    // async reset mid-request, preferably with select 2
    for (int s = 0; s < 30; s++) begin
      tick_until_decide(d);
      await_load(d);
      if (d == 2'd2 || s == 29) break;
      step(1'b1, 1'b0, 1'b1);
      check1("search_ack_load", load, 1'b0);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check1("async_reset_load", load, 1'b0);
    check2("async_reset_select", sel, 2'd0);
    check1("async_reset_overrun", ovr, 1'b0);
    ack = 1'b0;
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mlfsr = 8'hA5;
    model_clear();
    step(1'b1, 1'b0, 1'b0);
    run_slots(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cc_random_scheduler.md
Name: cc_random_scheduler

Overview:
- Controller that drives the 2-bit select of the 4:1 obstacle multiplexer. Select 0 = NADA (empty row); 1/2/3 = RANDOM1/2/3.
- Once every PERIOD game-advance ticks it picks the next source with an internal LFSR, applies spacing rules, and presents the choice through a req/ack handshake to the row-loading logic.
- Sits between the game timing unit, which supplies the tick, and the mux and row register.

Parameters:
- SCHED_SELECTWIDTH, 2, select bus width; the block encodes only values 0..3.
- SCHED_PERIOD, 4, ticks per slot; legal 1..2^SCHED_CNTWIDTH-1.
- SCHED_GAP, 2, number of forced NADA decisions after any nonzero decision; 0 disables forcing.
- SCHED_CNTWIDTH, 4, width of the tick counter and the gap counter.
- SCHED_SEED, 8'hA5, LFSR reset value; a value of 8'h00 is replaced by 8'h01.

Ports:
- CC_RANDOMSCHED_CLOCK_50  in  1  system clock; all state updates on its rising edge.
- CC_RANDOMSCHED_RESET_InLow  in  1  reset, asynchronous assert, active-low.
- CC_RANDOMSCHED_enable_In  in  1  1 = schedule; 0 = idle and abort.
- CC_RANDOMSCHED_tick_In  in  1  one-cycle pulse per game advance.
- CC_RANDOMSCHED_ack_In  in  1  consumer has taken the current select.
- CC_RANDOMSCHED_select_OutBUS  out  SCHED_SELECTWIDTH  mux select; registered.
- CC_RANDOMSCHED_load_Out  out  1  request; high while a new select awaits ack.
- CC_RANDOMSCHED_overrun_Out  out  1  sticky flag: a slot expired before ack.

Behaviour:
- Reset (async, RESET_InLow=0) sets:
  - state=IDLE, select=0, load=0, overrun=0;
  - tick counter=0, gap counter=0, last_random=0;
  - LFSR=SCHED_SEED (8'h01 if the seed is 0).
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1; shift left, new bit0 = b7^b5^b4^b3.
  - Advances every clock while enable=1 and holds while enable=0.
  - It never reaches 0.
- State machine, all transitions registered:
  - IDLE: load=0. When enable=1, go to COUNT with counter=0.
  - COUNT: each tick increments the counter. A tick that arrives while counter==SCHED_PERIOD-1 goes to DECIDE, and the counter is cleared on that same edge.
  - DECIDE (1 cycle): compute the candidate c = LFSR[1:0] as sampled in this cycle. Apply the rules below, register select, go to REQ.
  - REQ: load=1 and select held stable. When ack=1 is sampled, load returns to 0 on that edge and the state goes to COUNT.
- Decision rules, in priority order:
  - gap counter != 0: select=0 and the gap counter decrements.
  - c != 0 and c == last_random: select=0. This blocks a repeat of the same random source.
  - Otherwise select=c. If c != 0, last_random=c and the gap counter=SCHED_GAP.
- Latency: a terminal tick sampled at edge N gives DECIDE in cycle N..N+1, and load=1 with the new select visible after edge N+2.
- ack sampled while not in REQ is ignored.
- Ticks during DECIDE/REQ still increment the counter, so the next slot is measured from DECIDE entry.
- If the counter reaches SCHED_PERIOD-1 and another tick arrives while still in REQ:
  - overrun is set to 1 (sticky);
  - the counter saturates at SCHED_PERIOD-1;
  - the block stays in REQ and keeps the same select.
  - After ack it goes to DECIDE directly, not COUNT, and clears the counter.
- select holds its last value between requests; the mux keeps the last row source.
- tick and ack high in the same REQ cycle: ack is taken and the tick is counted.
- enable=0 in any state, on the next edge:
  - state=IDLE, load=0, select=0, overrun=0;
  - counters cleared, last_random=0;
  - the LFSR keeps its value.
- Async reset mid-REQ drops load and select to 0 immediately, without waiting for a clock.
- Widths: counters are SCHED_CNTWIDTH bits and do not wrap. The tick counter saturates and the gap counter stops at 0.

Test Plan:
- Reset with RESET_InLow=0, release, enable=0 and 10 ticks -> select=0, load=0, overrun=0 throughout; LFSR frozen at 8'hA5.
- enable=1, SCHED_PERIOD=4, ticks every 5 cycles, ack 3 cycles after each load -> load rises exactly 2 edges after every 4th tick, and select is stable while load=1.
- SCHED_GAP=2, run 40 slots, scoreboard against a reference LFSR model -> two NADA decisions follow every nonzero select, no two consecutive random decisions use the same source, and every select matches the model.
- Hold ack=0 for 5 extra ticks after a load -> overrun=1 at the tick that saturates the counter. On ack, DECIDE follows next edge and load re-asserts 2 edges after ack; overrun stays 1 until enable=0.
- Assert RESET_InLow=0 between clock edges while load=1 and select=2 -> load=0 and select=0 immediately; after release the first load occurs only after 4 new ticks.
- Drop enable for 1 cycle while in REQ -> load=0 and select=0 the next edge. After re-enable, a new slot starts from counter 0 and last_random=0, so a repeat of the previous source is permitted.
